// File: rtl/dpll_backtrack_ctrl_if.sv
// ---------------------------------------------------------------------------
// dpll_backtrack_ctrl_if
// Bundles the solver-side request/response signals and the formula-stack
// strobes/flags of the decision/backtrack controller.
//
// Modports:
//   slave  - the controller: takes requests and stack flags/data, and drives
//            responses, depth and the stack strobes/data.
//   master - the environment (solver core + formula stack): the reverse.
//
// Handshake: req_decide / req_backtrack are single-cycle pulses. They are
// only accepted while busy is low. Each accepted request produces exactly
// one resp_valid pulse. The resp_* fields hold their value until the next
// response.
// ---------------------------------------------------------------------------
interface dpll_backtrack_ctrl_if #(
    parameter int LIT_W  = 8,
    parameter int FORM_W = 16,
    parameter int DEPTH  = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic              req_decide;
    logic              req_backtrack;
    logic [FORM_W-1:0] req_formula;
    logic [LIT_W-1:0]  req_lit;
    logic              busy;
    logic              resp_valid;
    logic [1:0]        resp_status;
    logic [FORM_W-1:0] resp_formula;
    logic [LIT_W-1:0]  resp_lit;
    logic [DW-1:0]     depth;
    logic              stk_wr_en;
    logic              stk_pop;
    logic [FORM_W-1:0] stk_din;
    logic              stk_full;
    logic              stk_empty;
    logic [FORM_W-1:0] stk_dout;

    modport slave (
        input  req_decide, req_backtrack, req_formula, req_lit,
        input  stk_full, stk_empty, stk_dout,
        output busy, resp_valid, resp_status, resp_formula, resp_lit,
        output depth, stk_wr_en, stk_pop, stk_din
    );

    modport master (
        output req_decide, req_backtrack, req_formula, req_lit,
        output stk_full, stk_empty, stk_dout,
        input  busy, resp_valid, resp_status, resp_formula, resp_lit,
        input  depth, stk_wr_en, stk_pop, stk_din
    );
endinterface

// File: rtl/dpll_backtrack_ctrl.sv
// ---------------------------------------------------------------------------
// dpll_backtrack_ctrl
// Decision/backtrack controller for a DPLL solver. On a decision it pushes
// the formula snapshot onto the external formula stack and records the
// decision literal locally. On a conflict it pops levels until it finds one
// whose second polarity has not been tried yet. It re-pushes that level's
// formula, marked as flipped, and returns the formula together with the
// negated literal. If every level is exhausted it reports UNSAT.
//
// Ports:
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   bus            - dpll_backtrack_ctrl_if.slave (requests, responses,
//                    depth, formula-stack strobes/flags/data)
//   state_dbg      - current FSM state encoding
//   stat_*         - statistics outputs, present only with BACKTRACK_STATS_EN
//
// Build option: define BACKTRACK_STATS_EN to add the saturating counters
// stat_decisions, stat_backtracks and stat_max_depth.
//
// Response status: 00 OK, 01 RESTORED, 10 UNSAT, 11 OVERFLOW.
// ---------------------------------------------------------------------------
module dpll_backtrack_ctrl #(
    parameter int DEPTH  = 4,   // matches the formula stack size
    parameter int LIT_W  = 8,   // MSB = sign, low bits = variable index
    parameter int FORM_W = 16   // width of one formula snapshot
) (
    input  logic                       clock,
    input  logic                       reset_n,
    dpll_backtrack_ctrl_if.slave       bus,
    output logic [2:0]                 state_dbg
`ifdef BACKTRACK_STATS_EN
    ,
    output logic [31:0]                stat_decisions,
    output logic [31:0]                stat_backtracks,
    output logic [$clog2(DEPTH+1)-1:0] stat_max_depth
`endif
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
    localparam logic [LIT_W-1:0] SIGN_MASK = {1'b1, {(LIT_W-1){1'b0}}};

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_RESTORED = 2'b01;
    localparam logic [1:0] ST_UNSAT    = 2'b10;
    localparam logic [1:0] ST_OVERFLOW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PUSH   = 3'd1,
        S_POP    = 3'd2,
        S_WAIT   = 3'd3,
        S_REPUSH = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state;
    logic [DW-1:0]     depth_q;
    logic [DEPTH-1:0]  flip_mem;
    logic [LIT_W-1:0]  lit_mem [DEPTH];
    logic              busy_q;
    logic              resp_valid_q;
    logic [1:0]        resp_status_q;
    logic [FORM_W-1:0] resp_formula_q;
    logic [LIT_W-1:0]  resp_lit_q;
    logic              wr_en_q;
    logic              pop_q;
    logic [FORM_W-1:0] din_q;

    // The stack's empty flag lags by one pop at the last entry, so the
    // internal depth counter is the only source of truth for control.
    logic unused_stk_empty;
    assign unused_stk_empty = bus.stk_empty;

    logic [AW-1:0] idx;
    logic          at_full;
    logic          decide_ok;
    assign idx       = depth_q[AW-1:0];
    assign at_full   = (depth_q == DEPTH_MAX) || bus.stk_full;
    assign decide_ok = (state == S_IDLE) && !bus.req_backtrack &&
                       bus.req_decide && !at_full;

    // Literal storage carries no reset. Each entry is written before it
    // can be read back, because a level only exists after its push.
    always_ff @(posedge clock) begin
        if (decide_ok) lit_mem[idx] <= bus.req_lit;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            depth_q        <= '0;
            flip_mem       <= '0;
            busy_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_status_q  <= ST_OK;
            resp_formula_q <= '0;
            resp_lit_q     <= '0;
            wr_en_q        <= 1'b0;
            pop_q          <= 1'b0;
            din_q          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Backtrack has priority over a simultaneous decide.
                    if (bus.req_backtrack) begin
                        busy_q <= 1'b1;
                        if (depth_q == '0) begin
                            state         <= S_DONE;
                            resp_valid_q  <= 1'b1;
                            resp_status_q <= ST_UNSAT;
                        end else begin
                            state <= S_POP;
                            pop_q <= 1'b1;
                        end
                    end else if (bus.req_decide) begin
                        busy_q <= 1'b1;
                        if (at_full) begin
                            state         <= S_DONE;
                            resp_valid_q  <= 1'b1;
                            resp_status_q <= ST_OVERFLOW;
                        end else begin
                            state         <= S_PUSH;
                            wr_en_q       <= 1'b1;
                            din_q         <= bus.req_formula;
                            flip_mem[idx] <= 1'b0;
                        end
                    end
                end
                S_PUSH: begin
                    wr_en_q       <= 1'b0;
                    depth_q       <= depth_q + 1'b1;
                    state         <= S_DONE;
                    resp_valid_q  <= 1'b1;
                    resp_status_q <= ST_OK;
                end
                S_POP: begin
                    pop_q   <= 1'b0;
                    depth_q <= depth_q - 1'b1;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // depth_q now indexes the level that was just popped.
                    // stk_dout holds its formula this cycle.
                    if (!flip_mem[idx]) begin
                        state         <= S_REPUSH;
                        wr_en_q       <= 1'b1;
                        din_q         <= bus.stk_dout;
                        flip_mem[idx] <= 1'b1;
                    end else if (depth_q == '0) begin
                        state         <= S_DONE;
                        resp_valid_q  <= 1'b1;
                        resp_status_q <= ST_UNSAT;
                    end else begin
                        state <= S_POP;
                        pop_q <= 1'b1;
                    end
                end
                S_REPUSH: begin
                    wr_en_q        <= 1'b0;
                    depth_q        <= depth_q + 1'b1;
                    state          <= S_DONE;
                    resp_valid_q   <= 1'b1;
                    resp_status_q  <= ST_RESTORED;
                    resp_formula_q <= din_q;
                    resp_lit_q     <= lit_mem[idx] ^ SIGN_MASK;
                end
                S_DONE: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_status  = resp_status_q;
    assign bus.resp_formula = resp_formula_q;
    assign bus.resp_lit     = resp_lit_q;
    assign bus.depth        = depth_q;
    assign bus.stk_wr_en    = wr_en_q;
    assign bus.stk_pop      = pop_q;
    assign bus.stk_din      = din_q;
    assign state_dbg        = state;

`ifdef BACKTRACK_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_decisions  <= '0;
            stat_backtracks <= '0;
            stat_max_depth  <= '0;
        end else begin
            if (resp_valid_q && resp_status_q == ST_OK && stat_decisions != '1)
                stat_decisions <= stat_decisions + 1'b1;
            if (resp_valid_q && (resp_status_q == ST_RESTORED ||
                                 resp_status_q == ST_UNSAT) &&
                stat_backtracks != '1)
                stat_backtracks <= stat_backtracks + 1'b1;
            if (depth_q > stat_max_depth)
                stat_max_depth <= depth_q;
        end
    end
`endif
endmodule

// File: tb/tb_dpll_backtrack_ctrl.sv
module tb_dpll_backtrack_ctrl;
    localparam int DEPTH = 4;
    localparam int LW    = 8;
    localparam int FW    = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [1:0] OK       = 2'b00;
    localparam logic [1:0] RESTORED = 2'b01;
    localparam logic [1:0] UNSAT    = 2'b10;
    localparam logic [1:0] OVERFLOW = 2'b11;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dpll_backtrack_ctrl_if #(.LIT_W(LW), .FORM_W(FW), .DEPTH(DEPTH)) bus ();
    logic [2:0] state_dbg;
`ifdef BACKTRACK_STATS_EN
    logic [31:0]   stat_decisions;
    logic [31:0]   stat_backtracks;
    logic [DW-1:0] stat_max_depth;
`endif

    dpll_backtrack_ctrl #(.DEPTH(DEPTH), .LIT_W(LW), .FORM_W(FW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef BACKTRACK_STATS_EN
        ,
        .stat_decisions  (stat_decisions),
        .stat_backtracks (stat_backtracks),
        .stat_max_depth  (stat_max_depth)
`endif
    );

    // ---------------- formula stack model ----------------
    logic [FW-1:0] stk_mem [0:7];
    logic [FW-1:0] stk_dout_r;
    int            sp;
    int            push_cnt = 0;
    int            pop_cnt = 0;
    int            both_cnt = 0;
    logic          force_full = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp         <= 0;
            stk_dout_r <= '0;
        end else begin
            if (bus.stk_wr_en) begin
                stk_mem[sp] <= bus.stk_din;
                sp          <= sp + 1;
                push_cnt    <= push_cnt + 1;
            end
            if (bus.stk_pop) begin
                stk_dout_r <= stk_mem[sp-1];
                sp         <= sp - 1;
                pop_cnt    <= pop_cnt + 1;
            end
        end
    end

    assign bus.stk_full  = (sp == DEPTH) || force_full;
    assign bus.stk_empty = (sp == 0);
    assign bus.stk_dout  = stk_dout_r;

    always @(negedge clock) if (bus.stk_wr_en && bus.stk_pop) both_cnt++;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    int            r_cyc;
    logic [1:0]    r_status;
    logic [FW-1:0] r_formula;
    logic [LW-1:0] r_lit;
    logic [DW-1:0] r_depth;

    // Pulse a request for one cycle, then report the cycle of resp_valid
    // counted from the request edge (cycle 0).
    task automatic run_req(input logic d, input logic b,
                           input logic [FW-1:0] f, input logic [LW-1:0] l);
        int n;
        @(negedge clock);
        bus.req_decide    = d;
        bus.req_backtrack = b;
        bus.req_formula   = f;
        bus.req_lit       = l;
        @(negedge clock);
        bus.req_decide    = 1'b0;
        bus.req_backtrack = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        r_cyc     = bus.resp_valid ? n : 99;
        r_status  = bus.resp_status;
        r_formula = bus.resp_formula;
        r_lit     = bus.resp_lit;
        r_depth   = bus.depth;
    endtask

    int p0;

    initial begin
        bus.req_decide    = 1'b0;
        bus.req_backtrack = 1'b0;
        bus.req_formula   = '0;
        bus.req_lit       = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Reset state
        check("rst_busy",   32'(bus.busy), 32'h0);
        check("rst_valid",  32'(bus.resp_valid), 32'h0);
        check("rst_status", 32'(bus.resp_status), 32'h0);
        check("rst_form",   32'(bus.resp_formula), 32'h0);
        check("rst_lit",    32'(bus.resp_lit), 32'h0);
        check("rst_depth",  32'(bus.depth), 32'h0);
        check("rst_strobe", 32'({bus.stk_wr_en, bus.stk_pop}), 32'h0);
        check("rst_state",  32'(state_dbg), 32'h0);

        // Backtrack on empty -> UNSAT in cycle 1, no pop
        run_req(1'b0, 1'b1, '0, '0);
        check("bt0_cyc",    32'(r_cyc), 32'd1);
        check("bt0_status", 32'(r_status), 32'(UNSAT));
        check("bt0_depth",  32'(r_depth), 32'd0);
        check("bt0_pops",   32'(pop_cnt), 32'd0);

        // Decide F1/0x03, then backtrack -> RESTORED in cycle 4
        run_req(1'b1, 1'b0, 16'hA1A1, 8'h03);
        check("d1_cyc",    32'(r_cyc), 32'd2);
        check("d1_status", 32'(r_status), 32'(OK));
        check("d1_depth",  32'(r_depth), 32'd1);
        check("d1_stack",  32'(stk_mem[0]), 32'hA1A1);
        run_req(1'b0, 1'b1, '0, '0);
        check("r1_cyc",    32'(r_cyc), 32'd4);
        check("r1_status", 32'(r_status), 32'(RESTORED));
        check("r1_form",   32'(r_formula), 32'hA1A1);
        check("r1_lit",    32'(r_lit), 32'h83);
        check("r1_depth",  32'(r_depth), 32'd1);

        // Second backtrack: the only level is exhausted -> UNSAT (POP, WAIT, DONE)
        run_req(1'b0, 1'b1, '0, '0);
        check("u1_cyc",    32'(r_cyc), 32'd3);
        check("u1_status", 32'(r_status), 32'(UNSAT));
        check("u1_depth",  32'(r_depth), 32'd0);
        check("u1_push",   32'(push_cnt), 32'd2);
        check("u1_pop",    32'(pop_cnt), 32'd2);
        check("u1_sp",     32'(sp), 32'd0);

        // Two levels: restore F2, then skip exhausted level and restore F1
        run_req(1'b1, 1'b0, 16'hA1A1, 8'h03);
        run_req(1'b1, 1'b0, 16'hB2B2, 8'h05);
        check("d2_depth", 32'(r_depth), 32'd2);
        run_req(1'b0, 1'b1, '0, '0);
        check("r2_cyc",  32'(r_cyc), 32'd4);
        check("r2_form", 32'(r_formula), 32'hB2B2);
        check("r2_lit",  32'(r_lit), 32'h85);
        run_req(1'b0, 1'b1, '0, '0);
        check("r3_cyc",    32'(r_cyc), 32'd6);
        check("r3_status", 32'(r_status), 32'(RESTORED));
        check("r3_form",   32'(r_formula), 32'hA1A1);
        check("r3_lit",    32'(r_lit), 32'h83);
        check("r3_depth",  32'(r_depth), 32'd1);
        run_req(1'b0, 1'b1, '0, '0);
        check("u2_status", 32'(r_status), 32'(UNSAT));
        check("u2_depth",  32'(r_depth), 32'd0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++)
            run_req(1'b1, 1'b0, 16'(16'h1001 + i), 8'(8'h11 + i));
        check("fill_depth", 32'(r_depth), 32'(DEPTH));
        p0 = push_cnt;
        run_req(1'b1, 1'b0, 16'hDEAD, 8'h7F);
        check("ov_cyc",    32'(r_cyc), 32'd1);
        check("ov_status", 32'(r_status), 32'(OVERFLOW));
        check("ov_depth",  32'(r_depth), 32'(DEPTH));
        check("ov_nopush", 32'(push_cnt), 32'(p0));

        // Simultaneous decide + backtrack -> backtrack wins
        run_req(1'b1, 1'b1, 16'hBEEF, 8'h22);
        check("sim_cyc",    32'(r_cyc), 32'd4);
        check("sim_status", 32'(r_status), 32'(RESTORED));
        check("sim_form",   32'(r_formula), 32'h1004);
        check("sim_lit",    32'(r_lit), 32'h94);

        // Reset asserted during WAIT
        @(negedge clock);
        bus.req_backtrack = 1'b1;
        @(negedge clock);
        bus.req_backtrack = 1'b0;
        @(negedge clock);
        check("mid_state", 32'(state_dbg), 32'd3);
        reset_n = 1'b0;
        #1;
        check("ar_state",  32'(state_dbg), 32'd0);
        check("ar_busy",   32'(bus.busy), 32'h0);
        check("ar_depth",  32'(bus.depth), 32'h0);
        check("ar_resp",   32'({bus.resp_valid, bus.resp_status, bus.resp_lit}), 32'h0);
        check("ar_form",   32'(bus.resp_formula), 32'h0);
        check("ar_strobe", 32'({bus.stk_wr_en, bus.stk_pop}), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // After reset: push lands at depth 0 and the flip bit is clear
        run_req(1'b1, 1'b0, 16'hC3C3, 8'h07);
        check("pr_cyc",   32'(r_cyc), 32'd2);
        check("pr_depth", 32'(r_depth), 32'd1);
        check("pr_sp",    32'(sp), 32'd1);
        check("pr_stack", 32'(stk_mem[0]), 32'hC3C3);
        run_req(1'b0, 1'b1, '0, '0);
        check("pr_status", 32'(r_status), 32'(RESTORED));
        check("pr_lit",    32'(r_lit), 32'h87);

        // Stack full flag alone forces overflow
        force_full = 1'b1;
        run_req(1'b1, 1'b0, 16'h5555, 8'h09);
        force_full = 1'b0;
        check("ff_cyc",    32'(r_cyc), 32'd1);
        check("ff_status", 32'(r_status), 32'(OVERFLOW));
        check("ff_depth",  32'(r_depth), 32'd1);

        check("strobe_excl", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
